// File: rtl/pause_dim_ctrl.sv
// rtl/pause_dim_ctrl.sv - core pause arbitration with timed video dimming while paused
module pause_dim_ctrl #(
  parameter int RW            = 4,
  parameter int GW            = 4,
  parameter int BW            = 4,
  parameter int NREQ          = 1,
  parameter int TICKS_PER_SEC = 12000000,
  parameter int DIM_SECONDS   = 10,
  parameter int DIM_SHIFT     = 1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  user_button,
  input  logic [NREQ-1:0]       pause_request,
  input  logic                  OSD_STATUS,
  input  logic [1:0]            options,
  input  logic [RW+GW+BW-1:0]   rgb_in,
  output logic [RW+GW+BW-1:0]   rgb_out,
  output logic                  pause_cpu,
  output logic                  dim_active
);

  localparam int CW = RW + GW + BW;
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]    SEC_MAX   = 8'(DIM_SECONDS);

  logic          button_q;
  logic          toggle;
  logic [PW-1:0] presc;
  logic [7:0]    secs;

  logic          button_rise;
  logic          sec_tick;
  logic          pause_next;
  logic [RW-1:0] r_dim;
  logic [GW-1:0] g_dim;
  logic [BW-1:0] b_dim;

  always_comb begin
    button_rise = user_button & ~button_q;
    sec_tick    = (presc == PRESC_MAX);
    pause_next  = toggle | (OSD_STATUS & options[0]) | (|pause_request);
    // Each channel is shifted on its own so high bits never bleed into the neighbour.
    r_dim       = rgb_in[CW-1 -: RW] >> DIM_SHIFT;
    g_dim       = rgb_in[GW+BW-1 -: GW] >> DIM_SHIFT;
    b_dim       = rgb_in[BW-1:0] >> DIM_SHIFT;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // Track the live button level so a press held across reset release is not seen as an edge.
      button_q   <= user_button;
      toggle     <= 1'b0;
      presc      <= '0;
      secs       <= '0;
      pause_cpu  <= 1'b0;
      dim_active <= 1'b0;
      rgb_out    <= '0;
    end else begin
      button_q  <= user_button;
      if (button_rise) begin
        toggle <= ~toggle;
      end
      pause_cpu <= pause_next;

      if (!pause_cpu) begin
        presc <= '0;
        secs  <= '0;
      end else begin
        presc <= sec_tick ? '0 : presc + 1'b1;
        if (sec_tick && (secs != SEC_MAX)) begin
          secs <= secs + 8'd1;
        end
      end

      // Dim enable is re-evaluated every cycle, so toggling options[1] acts without a new wait.
      dim_active <= pause_cpu & options[1] & (secs == SEC_MAX);
      rgb_out    <= dim_active ? {r_dim, g_dim, b_dim} : rgb_in;
    end
  end

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// tb/tb_pause_dim_ctrl.sv - scoreboard bench for pause_dim_ctrl
module tb_pause_dim_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        user_button;
  logic [1:0]  pause_request;
  logic        OSD_STATUS;
  logic [1:0]  options;
  logic [11:0] rgb_in;
  logic [11:0] rgb_out;
  logic        pause_cpu;
  logic        dim_active;

  pause_dim_ctrl #(
    .RW(4), .GW(4), .BW(4), .NREQ(2),
    .TICKS_PER_SEC(4), .DIM_SECONDS(2), .DIM_SHIFT(1)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .user_button  (user_button),
    .pause_request(pause_request),
    .OSD_STATUS   (OSD_STATUS),
    .options      (options),
    .rgb_in       (rgb_in),
    .rgb_out      (rgb_out),
    .pause_cpu    (pause_cpu),
    .dim_active   (dim_active)
  );

  always #5 clk_sys = ~clk_sys;

  localparam int SEL_PAUSE = 0;
  localparam int SEL_DIM   = 1;
  localparam int SEL_RGB   = 2;

  typedef struct {
    string tag;
    int    due;
    int    sel;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_err  = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic sb_push(input string tag, input int d, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.due = cyc + d;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Pop every expectation due this cycle, sampled mid-cycle away from the active edge.
  always @(negedge clk_sys) begin
    int i;
    int act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        case (sb[i].sel)
          SEL_PAUSE: act = int'(pause_cpu);
          SEL_DIM:   act = int'(dim_active);
          default:   act = int'(rgb_out);
        endcase
        chk(sb[i].tag, act, sb[i].val);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    user_button   = 1'b0;
    pause_request = 2'b00;
    OSD_STATUS    = 1'b0;
    options       = 2'b00;
    rgb_in        = 12'h000;
    tick(2);
    sb_push("rst_pause", 0, SEL_PAUSE, 0);
    sb_push("rst_dim",   0, SEL_DIM,   0);
    sb_push("rst_rgb",   0, SEL_RGB,   0);

    // Unpaused passthrough.
    reset  = 1'b0;
    rgb_in = 12'h123;
    sb_push("pass_rgb", 1, SEL_RGB, 12'h123);
    tick(2);

    // Button press held 10 cycles: pause two edges after rise, one flip only.
    user_button = 1'b1;
    sb_push("btn_lat1", 1, SEL_PAUSE, 0);
    for (int d = 2; d <= 10; d++) sb_push("btn_hold", d, SEL_PAUSE, 1);
    for (int d = 1; d <= 10; d++) sb_push("btn_nodim", d, SEL_DIM, 0);
    tick(10);
    user_button = 1'b0;
    sb_push("btn_rel", 1, SEL_PAUSE, 1);
    sb_push("btn_rel", 2, SEL_PAUSE, 1);
    tick(2);
    user_button = 1'b1;
    sb_push("btn2_lat1", 1, SEL_PAUSE, 1);
    sb_push("btn2_off",  2, SEL_PAUSE, 0);
    tick(3);
    user_button = 1'b0;
    tick(2);

    // User pause with dim enabled: dim appears 9 cycles after pause_cpu rises.
    options     = 2'b11;
    user_button = 1'b1;
    sb_push("dim_pause", 2, SEL_PAUSE, 1);
    sb_push("dim_early", 10, SEL_DIM, 0);
    sb_push("dim_on",    11, SEL_DIM, 1);
    tick(3);
    user_button = 1'b0;
    tick(8);
    rgb_in = 12'hFA6;
    sb_push("dim_rgb_fa6", 1, SEL_RGB, 12'h753);
    sb_push("dim_hold",    1, SEL_DIM, 1);
    tick(1);
    rgb_in = 12'h888;
    sb_push("dim_rgb_888", 1, SEL_RGB, 12'h444);
    tick(1);
    rgb_in = 12'h111;
    sb_push("dim_rgb_111", 1, SEL_RGB, 12'h000);
    tick(1);

    // Reset mid-dim with the button held, then released from reset still held.
    reset       = 1'b1;
    user_button = 1'b1;
    sb_push("rstdim_pause", 1, SEL_PAUSE, 0);
    sb_push("rstdim_dim",   1, SEL_DIM,   0);
    sb_push("rstdim_rgb",   1, SEL_RGB,   0);
    tick(2);
    reset = 1'b0;
    for (int d = 1; d <= 4; d++) sb_push("rstrel_pause", d, SEL_PAUSE, 0);
    for (int d = 1; d <= 4; d++) sb_push("rstrel_dim",   d, SEL_DIM,   0);
    tick(4);
    user_button = 1'b0;
    tick(2);

    // OSD pause for exactly 3 cycles, never long enough to dim.
    options    = 2'b11;
    OSD_STATUS = 1'b1;
    sb_push("osd_pre", 0, SEL_PAUSE, 0);
    for (int d = 1; d <= 3; d++) sb_push("osd_on", d, SEL_PAUSE, 1);
    sb_push("osd_off", 4, SEL_PAUSE, 0);
    sb_push("osd_off", 5, SEL_PAUSE, 0);
    for (int d = 1; d <= 8; d++) sb_push("osd_nodim", d, SEL_DIM, 0);
    tick(3);
    OSD_STATUS = 1'b0;
    tick(5);

    // Fresh pause after the OSD blip takes the full wait, showing counters were cleared.
    options       = 2'b10;
    pause_request = 2'b01;
    sb_push("clr_pause", 1, SEL_PAUSE, 1);
    sb_push("clr_early", 9, SEL_DIM, 0);
    sb_push("clr_dim",  10, SEL_DIM, 1);
    tick(10);
    pause_request = 2'b00;
    sb_push("unp_pause",  1, SEL_PAUSE, 0);
    sb_push("unp_dimlag", 1, SEL_DIM, 1);
    sb_push("unp_dimoff", 2, SEL_DIM, 0);
    tick(3);

    // External hold with dim disabled, then enabling dim acts at once.
    options       = 2'b00;
    pause_request = 2'b10;
    for (int d = 1; d <= 20; d++) sb_push("req_pause", d, SEL_PAUSE, 1);
    for (int d = 1; d <= 20; d++) sb_push("req_nodim", d, SEL_DIM, 0);
    tick(20);
    options = 2'b10;
    rgb_in  = 12'hFA6;
    sb_push("req_dim_on",  1, SEL_DIM, 1);
    sb_push("req_rgb_pre", 1, SEL_RGB, 12'hFA6);
    sb_push("req_rgb_dim", 2, SEL_RGB, 12'h753);
    tick(3);
    pause_request = 2'b00;
    options       = 2'b00;
    sb_push("req_release", 1, SEL_PAUSE, 0);
    tick(3);

    if (sb.size() != 0) chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
